// File: rtl/multiword_adder_sequencer.sv
// Multiword adder/subtractor: one WORD_WIDTH-bit adder stepped LSW-first
// over WORD_COUNT slices. Carry is chained between slices; once the last
// slice is done the per-bit carry-in vector, carry out and signed overflow
// are registered alongside the sum. Valid/ready handshakes on both sides.
module multiword_adder_sequencer #(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_COUNT = 4
) (
  input  logic                             clock,
  input  logic                             clear,
  input  logic                             input_valid,
  output logic                             input_ready,
  input  logic [WORD_WIDTH*WORD_COUNT-1:0] A,
  input  logic [WORD_WIDTH*WORD_COUNT-1:0] B,
  input  logic                             sub,
  input  logic                             carry_in,
  output logic                             output_valid,
  input  logic                             output_ready,
  output logic [WORD_WIDTH*WORD_COUNT-1:0] sum,
  output logic [WORD_WIDTH*WORD_COUNT-1:0] carries,
  output logic                             carry_out,
  output logic                             overflow
);

  localparam int TW = WORD_WIDTH * WORD_COUNT;
  localparam int KW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [TW-1:0]       a_reg;
  logic [TW-1:0]       b_reg;    // already inverted for subtraction
  logic                c_reg;    // carry into the current slice
  logic [WORD_WIDTH:0] slice;
  logic [TW-1:0]       sum_next;
  logic [TW-1:0]       carries_next;
  logic [31:0]         base;

  // Slice adder for index k, plus the full-width sum/carry vector as it will
  // look once this slice is written (used on the final slice).
  always_comb begin
    base         = 32'(k) * 32'(WORD_WIDTH);
    slice        = {1'b0, a_reg[base +: WORD_WIDTH]}
                 + {1'b0, b_reg[base +: WORD_WIDTH]}
                 + {{WORD_WIDTH{1'b0}}, c_reg};
    sum_next     = sum;
    sum_next[base +: WORD_WIDTH] = slice[WORD_WIDTH-1:0];
    carries_next = a_reg ^ b_reg ^ sum_next;
  end

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= IDLE;
      k            <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= 1'b0;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
      sum          <= '0;
      carries      <= '0;
      carry_out    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid) begin
            a_reg       <= A;
            b_reg       <= sub ? ~B : B;
            c_reg       <= sub | carry_in;
            k           <= '0;
            input_ready <= 1'b0;
            state       <= CALC;
          end
        end
        CALC: begin
          sum   <= sum_next;
          c_reg <= slice[WORD_WIDTH];
          if (k == LAST_K) begin
            carry_out    <= slice[WORD_WIDTH];
            carries      <= carries_next;
            overflow     <= slice[WORD_WIDTH] ^ carries_next[TW-1];
            output_valid <= 1'b1;
            state        <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (output_ready) begin
            output_valid <= 1'b0;
            input_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          output_valid <= 1'b0;
          input_ready  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed bench for multiword_adder_sequencer at 8-bit slices x 4 words.
module tb_multiword_adder_sequencer;

  logic        clk;
  logic        clear;
  logic        input_valid;
  logic        input_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        sub;
  logic        carry_in;
  logic        output_valid;
  logic        output_ready;
  logic [31:0] sum;
  logic [31:0] carries;
  logic        carry_out;
  logic        overflow;

  int tests;
  int fails;

  multiword_adder_sequencer #(.WORD_WIDTH(8), .WORD_COUNT(4)) dut (
    .clock        (clk),
    .clear        (clear),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .A            (A),
    .B            (B),
    .sub          (sub),
    .carry_in     (carry_in),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .sum          (sum),
    .carries      (carries),
    .carry_out    (carry_out),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then scramble the inputs (they must
  // be ignored) and count cycles until output_valid, bounded.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci, output int lat);
    A = a; B = b; sub = s; carry_in = ci; input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    A = $urandom; B = $urandom; sub = ~s; carry_in = ~ci;
    lat = 0;
    while (output_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op();
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    tests++;
    if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: input_ready=%b output_valid=%b, required 1/0",
               input_ready, output_valid);
    end
    tests++;
    if (sum !== 32'h0 || carries !== 32'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_results: sum=%h carries=%h co=%b ov=%b, required all zero",
               sum, carries, carry_out, overflow);
    end
  endtask

  task automatic test_add();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        tc [3];
    logic [31:0] es [3];
    logic [31:0] ec [3];
    logic        eco [3];
    logic        eov [3];
    int lat;
    ta = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678};
    tb = '{32'h00000001, 32'h00000001, 32'h0000FFFF};
    tc = '{1'b0, 1'b0, 1'b1};
    es = '{32'h00000000, 32'h80000000, 32'h12355678};
    ec = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0001FFFF};
    eco = '{1'b1, 1'b0, 1'b0};
    eov = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, tc[i], lat);
      tests++;
      if (lat !== 4) begin
        fails++;
        $display("FAIL add%0d_latency: got %0d cycles, required 4", i, lat);
      end
      tests++;
      if (sum !== es[i]) begin
        fails++;
        $display("FAIL add%0d_sum: got %h, required %h", i, sum, es[i]);
      end
      tests++;
      if (carries !== ec[i]) begin
        fails++;
        $display("FAIL add%0d_carries: got %h, required %h", i, carries, ec[i]);
      end
      tests++;
      if (carry_out !== eco[i] || overflow !== eov[i]) begin
        fails++;
        $display("FAIL add%0d_flags: co=%b ov=%b, required co=%b ov=%b",
                 i, carry_out, overflow, eco[i], eov[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        tc [3];
    logic [31:0] es [3];
    logic [31:0] ec [3];
    logic        eco [3];
    logic        eov [3];
    int lat;
    ta = '{32'h00000005, 32'h80000000, 32'h00000100};
    tb = '{32'h00000007, 32'h00000001, 32'h00000001};
    tc = '{1'b1, 1'b1, 1'b0};
    es = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h000000FF};
    ec = '{32'h00000003, 32'h00000001, 32'hFFFFFE01};
    eco = '{1'b0, 1'b1, 1'b1};
    eov = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b1, tc[i], lat);
      tests++;
      if (lat !== 4) begin
        fails++;
        $display("FAIL sub%0d_latency: got %0d cycles, required 4", i, lat);
      end
      tests++;
      if (sum !== es[i]) begin
        fails++;
        $display("FAIL sub%0d_sum: got %h, required %h", i, sum, es[i]);
      end
      tests++;
      if (carries !== ec[i]) begin
        fails++;
        $display("FAIL sub%0d_carries: got %h, required %h", i, carries, ec[i]);
      end
      tests++;
      if (carry_out !== eco[i] || overflow !== eov[i]) begin
        fails++;
        $display("FAIL sub%0d_flags: co=%b ov=%b, required co=%b ov=%b",
                 i, carry_out, overflow, eco[i], eov[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h00010000, 32'h0000FFFF, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL bp_latency: got %0d cycles, required 4", lat);
    end
    input_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++;
      if (output_valid !== 1'b1 || input_ready !== 1'b0 || sum !== 32'h0001FFFF ||
          carries !== 32'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b in_ready=%b sum=%h carries=%h co=%b ov=%b, required 1/0/0001ffff/00000000/0/0",
                 c, output_valid, input_ready, sum, carries, carry_out, overflow);
      end
    end
    input_valid = 1'b0;
    finish_op();
    tests++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: valid=%b in_ready=%b, required 0/1",
               output_valid, input_ready);
    end
    tests++;
    if (sum !== 32'h0001FFFF) begin
      fails++;
      $display("FAIL bp_retained_sum: got %h, required 0001ffff", sum);
    end
  endtask

  task automatic test_clear_mid();
    int lat;
    A = 32'hFFFFFFFF; B = 32'h00000001; sub = 1'b0; carry_in = 1'b0;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_mid_handshake: in_ready=%b valid=%b, required 1/0",
               input_ready, output_valid);
    end
    tests++;
    if (sum !== 32'h0 || carries !== 32'h0 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL clear_mid_results: sum=%h carries=%h co=%b, required zeros",
               sum, carries, carry_out);
    end
    tick();
    tick();
    tick();
    tests++;
    if (output_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_mid_discard: valid=%b, required 0", output_valid);
    end
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h00000002 || carries !== 32'h00000002) begin
      fails++;
      $display("FAIL clear_mid_next: lat=%0d sum=%h carries=%h, required 4/00000002/00000002",
               lat, sum, carries);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int seen_valid;
    first = -1;
    second = -1;
    seen_valid = 0;
    A = 32'h00000003; B = 32'h00000004; sub = 1'b0; carry_in = 1'b0;
    input_valid = 1'b1;
    output_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (input_ready === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (output_valid === 1'b1 && seen_valid == 0) begin
        seen_valid = 1;
        tests++;
        if (sum !== 32'h00000007) begin
          fails++;
          $display("FAIL b2b_sum: got %h, required 00000007", sum);
        end
      end
      tick();
    end
    input_valid = 1'b0;
    tests++;
    if (first < 0 || second < 0 || (second - first) != 6 || seen_valid == 0) begin
      fails++;
      $display("FAIL b2b_period: accepts at %0d and %0d, valid_seen=%0d, required spacing 6",
               first, second, seen_valid);
    end
    for (int c = 0; c < 20 && input_ready !== 1'b1; c++) tick();
    output_ready = 1'b0;
    tests++;
    if (input_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_drain: in_ready=%b, required 1", input_ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear = 1'b1;
    input_valid = 1'b0;
    output_ready = 1'b0;
    A = '0;
    B = '0;
    sub = 1'b0;
    carry_in = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_clear_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
